rx: RTL and testbench
=====================

Name: rx

Overview:
- UART serial receiver for the mini SPART: 8 data bits, no parity, LSB first, 1+ stop bits.
- Uses a 16x-oversampling enable pulse, Baud, produced by an external baud generator.
- Deserialises RxD into an 8-bit byte, presents it on RxD_data and flags it with RDA (received data available) for the bus interface.

Parameters:
- OVERSAMPLE, 16, Baud enable ticks per serial bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- RxD  input  1  serial line; idles high; asynchronous to clk.
- Baud  input  1  16x oversampling enable; synchronous to clk; high for one clk cycle per tick.
- RxD_data  output  8  last correctly framed byte received.
- RDA  output  1  high when RxD_data holds a new, unconsumed byte.

Behaviour:
- Reset (async, rst=1): state IDLE, tick and bit counters 0, shift register 0, RxD_data=8'h00, RDA=0, synchroniser flops set to 1 (line idle).
- RxD synchronisation: two flip-flops clocked by clk. All decisions below use the synchronised value (rxs).
- State and counter updates happen only on clk edges where Baud=1, except the RDA clear rule noted below.
- IDLE: on a Baud tick with rxs=0, go to START with tick counter = 0.
- START:
  - Count ticks until OVERSAMPLE/2 (8) ticks have elapsed, i.e. mid start bit.
  - If rxs=0 there: start bit confirmed; RDA cleared; go to DATA with tick=0, bit=0.
  - If rxs=1 there: glitch; return to IDLE with no output change.
- DATA:
  - Every OVERSAMPLE (16) ticks, sample rxs into the shift register, LSB first (first sampled bit becomes RxD_data[0]).
  - After DATA_BITS samples, go to STOP with tick=0.
- STOP:
  - After 16 ticks (mid stop bit), sample rxs.
  - If rxs=1: RxD_data <= shift register, RDA <= 1, go to IDLE.
  - If rxs=0 (framing error): discard the byte, leave RxD_data and RDA unchanged, go to IDLE (a new start bit is accepted only after the line has returned high).
- Additional stop bits are treated as idle line time.
- RDA is a level signal:
  - Set at the mid-stop-bit sample.
  - Held until the next confirmed start bit.
  - Not a single-cycle pulse.
- RxD_data holds its value until the next good frame. It never shows a partially assembled byte.
- Latency: RDA rises on the clk edge of the tick 8 after the start of the stop bit. This is approximately 9.5 bit times after the falling edge, plus 2 clk cycles of synchroniser delay.
- Baud must be low on cycles without a tick. With Baud held low, all state is frozen.
- Reset mid-frame aborts immediately. The partial byte is lost and reception resumes at the next falling edge after reset is released.
- Back-to-back frames (stop bit immediately followed by start bit) must be received without loss.

Test Plan:
- Reset/idle: assert rst with RxD=1, then release with no activity -> RxD_data=8'h00, RDA=0 throughout.
- Single byte: clk period 10, one Baud tick every 3 clks (bit time 48 clks), send start, bits 1,0,1,0,1,0,1,0 (bit0 first), stop -> RxD_data=8'h55, RDA=1 by mid stop bit, and still 1 after two stop bits of idle.
- Second byte after idle: send bits 0,1,0,1,0,1,0,1 -> RDA drops at the confirmed start bit, then RxD_data=8'hAA with RDA=1 after the stop bit; RxD_data stays 8'h55 during reception.
- Start glitch: RxD low for 3 ticks (less than half a bit), then high -> no state advance, RxD_data and RDA unchanged.
- Framing error: send 8'h3C with the stop bit driven low -> RxD_data keeps its previous value, RDA unchanged; a following good frame 8'hC3 is received correctly.
- Reset mid-frame: assert rst during bit 4 -> RDA=0 and RxD_data=8'h00 immediately; the next full frame 8'hF0 is received correctly.

Source files
------------

// File: rtl/rx.sv
// UART receiver: 16x-oversampled, 8N1 (1+ stop bits), LSB first.
// Deserialises RxD into RxD_data and holds RDA high until the next confirmed start bit.
module rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    input  logic                 Baud,
    output logic [DATA_BITS-1:0] RxD_data,
    output logic                 RDA
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Last tick index of half a bit (mid start bit) and of a full bit.
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // WAIT_HIGH holds off start detection after a framing error until the line idles.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   rda_q, rda_d;
    logic                   sync1_q, sync2_q;
    logic                   rxs;

    assign rxs      = sync2_q;
    assign RxD_data = data_q;
    assign RDA      = rda_q;

    // Two-flop synchroniser for the asynchronous serial line; resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RxD;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rda_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rda_q   <= rda_d;
        end
    end

    // Next-state logic; everything advances only on Baud ticks.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        rda_d   = rda_q;

        if (Baud) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d = '0;
                        if (!rxs) begin
                            rda_d   = 1'b0;
                            bit_d   = '0;
                            state_d = DATA;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                // Sample each data bit at its centre, shifting in LSB first.
                DATA: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                // Publish the byte only if the stop bit is high at its centre.
                STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rxs) begin
                            data_d  = shift_q;
                            rda_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                    tick_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx.sv
// Directed bench for the UART receiver: Baud every 3 clks, 48 clks per bit.
module tb_rx;

    localparam int unsigned BIT_CLKS = 48;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic       Baud;
    logic [7:0] rxd_data;
    logic       rda;

    int n_vec = 0;
    int n_bad = 0;

    rx dut (
        .clk      (clk),
        .rst      (rst),
        .RxD      (RxD),
        .Baud     (Baud),
        .RxD_data (rxd_data),
        .RDA      (rda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-in-three Baud enable, driven away from the active edge.
    initial begin
        int div;
        div  = 0;
        Baud = 1'b0;
        forever begin
            @(negedge clk);
            div  = (div == 2) ? 0 : div + 1;
            Baud = (div == 0);
        end
    end

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        wait_clks(BIT_CLKS);
    endtask

    // Send a full frame; after the start bit RDA must be cleared while RxD_data holds prev.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input logic [7:0] prev);
        send_bit(1'b0);
        check("rda_clr_after_start", 32'(rda), 32'(0));
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
            if (i == 4) check("data_hold_mid_frame", 32'(rxd_data), 32'(prev));
        end
        send_bit(stop_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        RxD = 1'b1;
        wait_clks(4);
        check("rst_data", 32'(rxd_data), 32'h00);
        check("rst_rda", 32'(rda), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_clks(BIT_CLKS);
            check("idle_data", 32'(rxd_data), 32'h00);
            check("idle_rda", 32'(rda), 32'(0));
        end

        // First byte 0x55, then two stop bits of idle.
        send_frame(8'h55, 1'b1, 8'h00);
        check("b55_data", 32'(rxd_data), 32'h55);
        check("b55_rda", 32'(rda), 32'(1));
        wait_clks(2 * BIT_CLKS);
        check("b55_rda_held", 32'(rda), 32'(1));
        check("b55_data_held", 32'(rxd_data), 32'h55);

        // Second byte 0xAA, directly followed by a back-to-back frame 0x81.
        send_frame(8'hAA, 1'b1, 8'h55);
        check("bAA_data", 32'(rxd_data), 32'hAA);
        check("bAA_rda", 32'(rda), 32'(1));
        send_frame(8'h81, 1'b1, 8'hAA);
        check("b81_b2b_data", 32'(rxd_data), 32'h81);
        check("b81_b2b_rda", 32'(rda), 32'(1));
        wait_clks(BIT_CLKS);

        // Start glitch: 3 ticks low is rejected at mid start bit.
        RxD = 1'b0;
        wait_clks(9);
        RxD = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_data", 32'(rxd_data), 32'h81);
        check("glitch_rda", 32'(rda), 32'(1));

        // Framing error: byte discarded; RDA was already cleared by the start bit.
        send_frame(8'h3C, 1'b0, 8'h81);
        check("ferr_data", 32'(rxd_data), 32'h81);
        check("ferr_rda", 32'(rda), 32'(0));
        RxD = 1'b1;
        wait_clks(BIT_CLKS);
        check("ferr_idle_rda", 32'(rda), 32'(0));
        send_frame(8'hC3, 1'b1, 8'h81);
        check("bC3_data", 32'(rxd_data), 32'hC3);
        check("bC3_rda", 32'(rda), 32'(1));
        wait_clks(BIT_CLKS);

        // Reset in the middle of bit 4 of frame 0xA5.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
        RxD = 1'b0;
        wait_clks(20);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(rxd_data), 32'h00);
        check("midrst_rda", 32'(rda), 32'(0));
        RxD = 1'b1;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(2 * BIT_CLKS);
        check("postrst_data", 32'(rxd_data), 32'h00);
        check("postrst_rda", 32'(rda), 32'(0));
        send_frame(8'hF0, 1'b1, 8'h00);
        check("bF0_data", 32'(rxd_data), 32'hF0);
        check("bF0_rda", 32'(rda), 32'(1));
        wait_clks(BIT_CLKS);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
